lcd1602_responder: RTL and testbench
====================================

Name: lcd1602_responder

Overview:
- Synthesizable HD44780-compatible receiver for the 8-bit 1602 LCD write bus.
- Decodes the command and data writes produced by the team's LCD driver and keeps an 80-byte DDRAM image plus display-control state.
- Exposes a synchronous read port so on-chip logic or a testbench can mirror or check the displayed text.
- Serves as a loopback/self-check target and as a bus model for driver verification.

Parameters:
- SYNC_STAGES, 2, number of flops synchronizing lcd_en/lcd_rs/lcd_rw/lcd_data (minimum 1).
- CLEAR_CHAR, 8'h20, byte written to every DDRAM cell by a clear.
- CLEAR_CYCLES, 80, number of DDRAM cells; cleared one per clk. Fixed by the 40x2 map.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- lcd_rs  in  1  0 = command, 1 = data.
- lcd_rw  in  1  0 = write; 1 = read, which is ignored.
- lcd_en  in  1  strobe; the transfer is taken on its falling edge.
- lcd_data  in  8  bus byte.
- rd_addr  in  7  DDRAM address to read, in HD44780 format.
- rd_data  out  8  DDRAM[rd_addr], registered.
- busy  out  1  clear in progress.
- cur_addr  out  7  current DDRAM address counter (AC).
- disp_on, cursor_on, blink_on  out  1 each  display-control bits D/C/B.
- inc_mode  out  1  entry-mode I/D bit.
- wr_pulse  out  1  one-cycle pulse for each accepted data write.
- err  out  1  sticky error flag.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - cur_addr = 0, inc_mode = 1.
  - disp_on, cursor_on, blink_on = 0.
  - wr_pulse = 0, err = 0, rd_data = 0.
  - busy = 0 while rst is high.
- In the first cycle after rst deasserts, an automatic clear starts (busy = 1). Reset asserted mid-clear aborts the clear; the clear restarts after release.
- Edge detect: inputs pass through SYNC_STAGES flops. A transfer is detected in cycle e, the first cycle in which the synchronized EN is 0 after being 1. RS/RW/DATA are taken from their synchronized values in cycle e-1. All effects are visible in cycle e+1.
- Transfers with RW = 1 are discarded with no side effects.
- A transfer detected while busy = 1 is discarded and sets err.
- Physical index map:
  - AC 0x00-0x27 maps to index AC.
  - AC 0x40-0x67 maps to index AC-0x40+40.
  - All other AC values are invalid.
- Commands (RS = 0), decoded by highest set bit:
  - 0x01 clear: AC = 0, inc_mode = 1. busy = 1 for exactly CLEAR_CYCLES cycles, starting in cycle e+1. Indices 0..79 are written with CLEAR_CHAR in ascending order.
  - 0x02/0x03 home: AC = 0; DDRAM is unchanged.
  - 0x04-0x07 entry mode: inc_mode = bit1. The shift bit is accepted and ignored.
  - 0x08-0x0F display control: disp_on = bit2, cursor_on = bit1, blink_on = bit0.
  - 0x10-0x1F shift:
    - bit3 = 0 moves AC by +1 if bit2 = 1, otherwise by -1, using the wrap rule below.
    - bit3 = 1 (display shift) is ignored.
  - 0x20-0x3F function set: accepted. bit4 = 0 (4-bit mode) sets err; the block stays in 8-bit mode.
  - 0x40-0x7F CGRAM address: enters CGRAM mode. Subsequent data writes are discarded, with no pulse and no err, until the next DDRAM-address or clear/home command.
  - 0x80-0xFF DDRAM address: AC = data[6:0]. An invalid address sets err but is still loaded.
- Data write (RS = 1, DDRAM mode):
  - Valid AC: DDRAM[index(AC)] = data, then AC steps per inc_mode, and wr_pulse = 1 in cycle e+1.
  - Invalid AC: no write, no pulse, err set, AC unchanged.
- AC wrap:
  - Increment: 0x27 goes to 0x40, and 0x67 goes to 0x00.
  - Decrement: 0x00 goes to 0x67, and 0x40 goes to 0x27.
- Read port: rd_data is registered with 1-cycle latency. An invalid rd_addr returns 8'h00. A read in the same cycle as a write to the same cell returns the old value.
- err clears only on rst.
- RAM is a simple dual-port array of 80x8 bits.

Test Plan:
- Release reset and hold idle -> busy = 1 for 80 cycles, then 0. rd_addr 0x00, 0x27, 0x40 and 0x67 all return 0x20. err = 0.
- Write 0x0C, 0x06, 0x80, then data "P","a","s","s" (the driver's init sequence) -> disp_on = 1, cursor_on = 0, blink_on = 0, inc_mode = 1. DDRAM 0x00-0x03 = 50 61 73 73, cur_addr = 0x04, four wr_pulses.
- Write 0xA7 (AC = 0x27), data 0x41, data 0x42 -> 0x27 = 0x41, 0x40 = 0x42, cur_addr = 0x41.
- Write 0x04 (decrement mode), 0xC0, data 0x5A -> DDRAM 0x40 = 0x5A, cur_addr = 0x27. Then 0x80, data 0x31 -> cur_addr = 0x67.
- Write 0x01, then a second command 10 cycles later -> the second command is dropped, err = 1, busy lasts exactly 80 cycles.
- Write 0xA8, then data 0x33 -> no write, err = 1. An RW = 1 transfer produces no change. Asserting rst mid-clear restarts the clear after release.

Source files
------------

// File: rtl/lcd1602_responder.sv
// lcd1602_responder: HD44780-compatible receiver for the 8-bit 1602 LCD write bus.
// Keeps an 80-byte DDRAM image plus display-control state and offers a registered
// read port so other logic can mirror the displayed text.
module lcd1602_responder #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [7:0]  CLEAR_CHAR   = 8'h20,
    parameter int unsigned CLEAR_CYCLES = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic [6:0] cur_addr,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_mode,
    output logic       wr_pulse,
    output logic       err
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    localparam int Stages = (SYNC_STAGES < 1) ? 1 : int'(SYNC_STAGES);

    // AC is valid in the two 40-cell windows 0x00-0x27 and 0x40-0x67.
    function automatic logic ac_valid(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    // Second line starts at index 40, i.e. AC - 0x40 + 40 = AC - 24.
    function automatic logic [6:0] ac_index(input logic [6:0] a);
        return a[6] ? (a - 7'd24) : a;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
        logic [6:0] n;
        if (up) begin
            case (a)
                7'h27:   n = 7'h40;
                7'h67:   n = 7'h00;
                default: n = a + 7'd1;
            endcase
        end else begin
            case (a)
                7'h00:   n = 7'h67;
                7'h40:   n = 7'h27;
                default: n = a - 7'd1;
            endcase
        end
        return n;
    endfunction

    // Bus word layout: {en, rs, rw, data}.
    logic [10:0] sync_q [Stages];
    logic [10:0] bus_s;
    logic [10:0] prev_q;
    logic        xfer;

    state_e      state_q, state_d;
    logic [6:0]  clr_idx_q, clr_idx_d;
    logic [6:0]  ac_q, ac_d;
    logic        inc_q, inc_d;
    logic        d_q, d_d, c_q, c_d, b_q, b_d;
    logic        cgram_q, cgram_d;
    logic        err_q, err_d;
    logic        wr_pulse_q, wr_pulse_d;
    logic [7:0]  rd_data_q;

    logic        we;
    logic [6:0]  waddr;
    logic [7:0]  wdata;
    logic [7:0]  mem [CLEAR_CYCLES];

    assign bus_s = sync_q[Stages-1];
    // Falling edge of the synchronized strobe; rs/rw/data come from the previous cycle.
    assign xfer  = prev_q[10] & ~bus_s[10];

    // Input synchronizer chain and one-cycle history for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Stages; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= {lcd_en, lcd_rs, lcd_rw, lcd_data};
            for (int i = 1; i < Stages; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= bus_s;
        end
    end

    // Control state; reset leaves the clear engine armed so it runs right after release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StClear;
            clr_idx_q  <= '0;
            ac_q       <= '0;
            inc_q      <= 1'b1;
            d_q        <= 1'b0;
            c_q        <= 1'b0;
            b_q        <= 1'b0;
            cgram_q    <= 1'b0;
            err_q      <= 1'b0;
            wr_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            ac_q       <= ac_d;
            inc_q      <= inc_d;
            d_q        <= d_d;
            c_q        <= c_d;
            b_q        <= b_d;
            cgram_q    <= cgram_d;
            err_q      <= err_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Next-state: clear sequencing, command decode and data writes.
    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        ac_d       = ac_q;
        inc_d      = inc_q;
        d_d        = d_q;
        c_d        = c_q;
        b_d        = b_q;
        cgram_d    = cgram_q;
        err_d      = err_q;
        wr_pulse_d = 1'b0;
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;

        if (state_q == StClear) begin
            we    = 1'b1;
            waddr = clr_idx_q;
            wdata = CLEAR_CHAR;
            if (clr_idx_q == 7'(CLEAR_CYCLES - 1)) state_d = StIdle;
            else clr_idx_d = clr_idx_q + 7'd1;
        end

        if (xfer && !prev_q[8]) begin
            if (state_q == StClear) begin
                err_d = 1'b1;
            end else if (!prev_q[9]) begin
                // Commands decode on the highest set bit.
                if (prev_q[7]) begin
                    ac_d    = prev_q[6:0];
                    cgram_d = 1'b0;
                    if (!ac_valid(prev_q[6:0])) err_d = 1'b1;
                end else if (prev_q[6]) begin
                    cgram_d = 1'b1;
                end else if (prev_q[5]) begin
                    if (!prev_q[4]) err_d = 1'b1;
                end else if (prev_q[4]) begin
                    if (!prev_q[3]) ac_d = ac_step(ac_q, prev_q[2]);
                end else if (prev_q[3]) begin
                    d_d = prev_q[2];
                    c_d = prev_q[1];
                    b_d = prev_q[0];
                end else if (prev_q[2]) begin
                    inc_d = prev_q[1];
                end else if (prev_q[1]) begin
                    ac_d    = '0;
                    cgram_d = 1'b0;
                end else if (prev_q[0]) begin
                    ac_d      = '0;
                    inc_d     = 1'b1;
                    cgram_d   = 1'b0;
                    state_d   = StClear;
                    clr_idx_d = '0;
                end
            end else if (!cgram_q) begin
                if (ac_valid(ac_q)) begin
                    we         = 1'b1;
                    waddr      = ac_index(ac_q);
                    wdata      = prev_q[7:0];
                    ac_d       = ac_step(ac_q, inc_q);
                    wr_pulse_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    // DDRAM write port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read port; same-cycle writes are seen on the following read.
    always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else rd_data_q <= ac_valid(rd_addr) ? mem[ac_index(rd_addr)] : 8'h00;
    end

    assign rd_data   = rd_data_q;
    assign busy      = (state_q == StClear) && !rst;
    assign cur_addr  = ac_q;
    assign disp_on   = d_q;
    assign cursor_on = c_q;
    assign blink_on  = b_q;
    assign inc_mode  = inc_q;
    assign wr_pulse  = wr_pulse_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lcd1602_responder.sv
// tb_lcd1602_responder: directed and randomized bus transfers against a linear-DDRAM model.
module tb_lcd1602_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic [6:0] cur_addr;
    logic       disp_on, cursor_on, blink_on, inc_mode, wr_pulse, err;

    always #5 clk = ~clk;

    lcd1602_responder dut (
        .clk       (clk),
        .rst       (rst),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_data  (lcd_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .cur_addr  (cur_addr),
        .disp_on   (disp_on),
        .cursor_on (cursor_on),
        .blink_on  (blink_on),
        .inc_mode  (inc_mode),
        .wr_pulse  (wr_pulse),
        .err       (err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int run_len  = 0;
    int last_run = 0;
    int pulse_cnt = 0;

    // Busy run lengths and write-pulse count, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_pulse) pulse_cnt <= pulse_cnt + 1;
        if (busy) run_len <= run_len + 1;
        else if (run_len != 0) begin
            last_run <= run_len;
            run_len  <= 0;
        end
    end

    // Reference model: DDRAM as a flat 80-cell line, AC converted to/from a position.
    logic [7:0] m_mem [80];
    logic [6:0] m_ac;
    bit         m_inc, m_d, m_c, m_b, m_cg, m_err;
    int         m_pulses = 0;

    function automatic bit m_valid(input logic [6:0] a);
        return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
    endfunction

    function automatic int m_pos(input logic [6:0] a);
        return (a < 7'h40) ? int'(a) : int'(a) - 64 + 40;
    endfunction

    function automatic logic [6:0] m_ac_of(input int p);
        return (p < 40) ? 7'(p) : 7'(p - 40 + 64);
    endfunction

    function automatic logic [6:0] m_step(input logic [6:0] a, input bit up);
        if (!m_valid(a)) return up ? a + 7'd1 : a - 7'd1;
        return m_ac_of((m_pos(a) + (up ? 1 : 79)) % 80);
    endfunction

    task automatic m_clear_mem();
        for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
    endtask

    task automatic model_reset();
        m_ac = 7'h00; m_inc = 1; m_d = 0; m_c = 0; m_b = 0; m_cg = 0; m_err = 0;
        m_clear_mem();
    endtask

    task automatic model_xfer(input bit rs, input bit rw, input logic [7:0] d, input bit dropped);
        if (rw) return;
        if (dropped) begin
            m_err = 1;
            return;
        end
        if (rs) begin
            if (m_cg) return;
            if (!m_valid(m_ac)) begin
                m_err = 1;
                return;
            end
            m_mem[m_pos(m_ac)] = d;
            m_ac = m_step(m_ac, m_inc);
            m_pulses++;
        end else if (d >= 8'h80) begin
            m_ac = d[6:0];
            m_cg = 0;
            if (!m_valid(d[6:0])) m_err = 1;
        end else if (d >= 8'h40) begin
            m_cg = 1;
        end else if (d >= 8'h20) begin
            if (!d[4]) m_err = 1;
        end else if (d >= 8'h10) begin
            if (!d[3]) m_ac = m_step(m_ac, d[2]);
        end else if (d >= 8'h08) begin
            m_d = d[2]; m_c = d[1]; m_b = d[0];
        end else if (d >= 8'h04) begin
            m_inc = d[1];
        end else if (d >= 8'h02) begin
            m_ac = 7'h00;
            m_cg = 0;
        end else if (d == 8'h01) begin
            m_ac = 7'h00;
            m_inc = 1;
            m_cg = 0;
            m_clear_mem();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lcd_xfer(input bit rs, input bit rw, input logic [7:0] d);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d;
        tick();
        lcd_en = 1'b1;
        repeat (2) tick();
        lcd_en = 1'b0;
        repeat (5) tick();
        lcd_rw = 1'b0;
    endtask

    task automatic send(input bit rs, input bit rw, input logic [7:0] d);
        lcd_xfer(rs, rw, d);
        model_xfer(rs, rw, d, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        if (busy) check("busy_timeout", 32'd1, 32'd0);
        tick();
    endtask

    task automatic read_check(input string tag, input logic [6:0] a);
        rd_addr = a;
        tick();
        check(tag, rd_data, m_valid(a) ? m_mem[m_pos(a)] : 8'h00);
    endtask

    task automatic check_state(input string tag);
        check({tag, "/ac"}, cur_addr, m_ac);
        check({tag, "/inc"}, inc_mode, m_inc);
        check({tag, "/dcb"}, {disp_on, cursor_on, blink_on}, {m_d, m_c, m_b});
        check({tag, "/err"}, err, m_err);
        check({tag, "/busy"}, busy, 0);
        check({tag, "/pulses"}, pulse_cnt, m_pulses);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        check("rst/busy_low", busy, 0);
        rst = 1'b0;
        model_reset();
        tick();
        check("rel/busy_high", busy, 1);
        wait_idle();
        check("rel/busy_len", last_run, 80);
    endtask

    task automatic random_step(input int it);
        int unsigned k;
        bit          rs, rw;
        logic [7:0]  d;
        k  = $urandom_range(0, 29);
        rs = 0;
        rw = 0;
        d  = 8'($urandom);
        if (k <= 6 || k >= 20) rs = 1;
        else if (k <= 8) d = {1'b1, m_ac_of(int'($urandom_range(0, 79)))};
        else if (k == 9) d = d | 8'h80;
        else if (k == 10) d = 8'h04 | (d & 8'h03);
        else if (k == 11) d = 8'h08 | (d & 8'h07);
        else if (k <= 13) d = 8'h10 | (d & 8'h0F);
        else if (k == 14) d = 8'h30 | (d & 8'h0F);
        else if (k == 15) d = 8'h20 | (d & 8'h1F);
        else if (k == 16) d = 8'h40 | (d & 8'h3F);
        else if (k == 17) d = 8'h02 | (d & 8'h01);
        else if (k == 18) rw = 1;
        else d = 8'h01;
        send(rs, rw, d);
        if (!rs && !rw && d == 8'h01) begin
            wait_idle();
            check("rnd/clear_len", last_run, 80);
        end
        check_state($sformatf("rnd%0d", it));
        read_check("rnd/rd_a", 7'($urandom));
        read_check("rnd/rd_b", m_ac_of(int'($urandom_range(0, 79))));
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; lcd_rs = 0; lcd_rw = 0; lcd_en = 0; lcd_data = 8'h00; rd_addr = 7'h00;
        repeat (3) tick();
        check("rst/busy", busy, 0);
        check("rst/ac", cur_addr, 0);
        check("rst/inc", inc_mode, 1);
        check("rst/dcb", {disp_on, cursor_on, blink_on}, 3'b000);
        check("rst/pulse", wr_pulse, 0);
        check("rst/err", err, 0);
        check("rst/rd", rd_data, 0);

        // Auto-clear after release.
        rst = 1'b0;
        model_reset();
        tick();
        check("boot/busy_high", busy, 1);
        wait_idle();
        check("boot/busy_len", last_run, 80);
        read_check("boot/rd00", 7'h00);
        read_check("boot/rd27", 7'h27);
        read_check("boot/rd40", 7'h40);
        read_check("boot/rd67", 7'h67);
        check("boot/err", err, 0);

        // Driver init sequence.
        send(0, 0, 8'h0C); send(0, 0, 8'h06); send(0, 0, 8'h80);
        send(1, 0, "P"); send(1, 0, "a"); send(1, 0, "s"); send(1, 0, "s");
        check_state("init");
        check("init/ac04", cur_addr, 7'h04);
        check("init/pulses4", pulse_cnt, 4);
        read_check("init/rd00", 7'h00);
        read_check("init/rd03", 7'h03);

        // Line-1 to line-2 wrap.
        send(0, 0, 8'hA7); send(1, 0, 8'h41); send(1, 0, 8'h42);
        check("wrap/ac41", cur_addr, 7'h41);
        read_check("wrap/rd27", 7'h27);
        read_check("wrap/rd40", 7'h40);

        // Decrement mode and backwards wraps.
        send(0, 0, 8'h04); send(0, 0, 8'hC0); send(1, 0, 8'h5A);
        check("dec/ac27", cur_addr, 7'h27);
        read_check("dec/rd40", 7'h40);
        send(0, 0, 8'h80); send(1, 0, 8'h31);
        check("dec/ac67", cur_addr, 7'h67);
        check_state("dec");

        // RW=1 transfer has no effect.
        send(1, 1, 8'h77);
        check_state("rw1");
        read_check("rw1/rd67", 7'h67);

        // Command during clear is dropped and flags err.
        lcd_xfer(0, 0, 8'h01);
        model_xfer(0, 0, 8'h01, 0);
        repeat (2) tick();
        lcd_xfer(0, 0, 8'h0F);
        model_xfer(0, 0, 8'h0F, 1);
        wait_idle();
        check("clr/busy_len", last_run, 80);
        check("clr/err", err, 1);
        check_state("clr");
        read_check("clr/rd00", 7'h00);

        // Data to an invalid AC.
        do_reset();
        send(0, 0, 8'hA8);
        check("inv/err_addr", err, 1);
        send(1, 0, 8'h33);
        check_state("inv");
        check("inv/ac", cur_addr, 7'h28);

        // Reset mid-clear restarts the clear.
        send(0, 0, 8'h01);
        repeat (20) tick();
        do_reset();
        check_state("midrst");
        read_check("midrst/rd00", 7'h00);
        read_check("midrst/rd67", 7'h67);

        for (int it = 0; it < 150; it++) random_step(it);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
